// File: rtl/gpu_bus_arbiter.sv
// gpu_bus_arbiter: round-robin arbiter for two GPU bus requesters plus a framebuffer commit sequencer
module gpu_bus_arbiter #(
  parameter logic [7:0]  GPUAddress    = 8'b00000010,
  parameter logic [10:0] ControlOffset = 11'd0,
  parameter logic [7:0]  PollInterval  = 8'd8,
  parameter logic [15:0] PollLimit     = 16'd2048
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [63:0] addr0,
  input  logic [63:0] addr1,
  input  logic [63:0] wdata0,
  input  logic [63:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [63:0] rdata,
  input  logic        commit,
  input  logic [63:0] controlBase,
  output logic        commitDone,
  output logic        commitError,
  output logic [63:0] busAddress,
  output logic [63:0] busDataOut,
  output logic        busRead,
  output logic        busWrite,
  output logic        busDataOutEnable,
  input  logic [63:0] busDataIn,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, ACCESS, RESPOND, COMMIT_WR, POLL_WAIT, POLL_RD, COMMIT_END} stateType;
  localparam logic [63:0] ControlAddress = {GPUAddress, 45'b0, ControlOffset};
  stateType    state;
  logic        grant;
  logic        lastGrant;
  logic        commitPending;
  logic [7:0]  waitCount;
  logic [15:0] pollCount;
  logic        pickOne;
  logic        pickWrite;
  logic        unusedControlBits;
  assign pickOne           = req1 && (!req0 || !lastGrant);
  assign pickWrite         = pickOne ? wr1 : wr0;
  assign busy              = state != IDLE;
  assign unusedControlBits = ^controlBase[1:0];
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      grant            <= 1'b0;
      lastGrant        <= 1'b1;
      commitPending    <= 1'b0;
      waitCount        <= 8'd0;
      pollCount        <= 16'd0;
      rdata            <= 64'd0;
      ack0             <= 1'b0;
      ack1             <= 1'b0;
      commitDone       <= 1'b0;
      commitError      <= 1'b0;
      busAddress       <= 64'd0;
      busDataOut       <= 64'd0;
      busRead          <= 1'b0;
      busWrite         <= 1'b0;
      busDataOutEnable <= 1'b0;
    end else begin
      // every pulse and bus drive defaults low so the bus is idle between accesses
      ack0             <= 1'b0;
      ack1             <= 1'b0;
      commitDone       <= 1'b0;
      commitError      <= 1'b0;
      busAddress       <= 64'd0;
      busDataOut       <= 64'd0;
      busRead          <= 1'b0;
      busWrite         <= 1'b0;
      busDataOutEnable <= 1'b0;
      if (commit) commitPending <= 1'b1;
      case (state)
        IDLE: begin
          if (commitPending) begin
            state            <= COMMIT_WR;
            commitPending    <= commit;
            pollCount        <= 16'd0;
            busAddress       <= ControlAddress;
            busDataOut       <= {controlBase[63:2], 2'b01};
            busWrite         <= 1'b1;
            busDataOutEnable <= 1'b1;
          end else if (req0 || req1) begin
            state            <= ACCESS;
            grant            <= pickOne;
            lastGrant        <= pickOne;
            busAddress       <= pickOne ? addr1 : addr0;
            busDataOut       <= pickWrite ? (pickOne ? wdata1 : wdata0) : 64'd0;
            busWrite         <= pickWrite;
            busRead          <= !pickWrite;
            busDataOutEnable <= pickWrite;
          end
        end
        ACCESS: begin
          state <= RESPOND;
          rdata <= busDataIn;
          ack0  <= !grant;
          ack1  <= grant;
        end
        RESPOND: state <= IDLE;
        COMMIT_WR: begin
          state     <= POLL_WAIT;
          waitCount <= PollInterval;
        end
        POLL_WAIT: begin
          if (waitCount <= 8'd1) begin
            state      <= POLL_RD;
            busRead    <= 1'b1;
            busAddress <= ControlAddress;
          end else waitCount <= waitCount - 8'd1;
        end
        POLL_RD: begin
          pollCount <= pollCount + 16'd1;
          if (!busDataIn[0]) begin
            state      <= COMMIT_END;
            commitDone <= 1'b1;
          end else if (pollCount + 16'd1 == PollLimit) begin
            state       <= COMMIT_END;
            commitError <= 1'b1;
          end else begin
            state     <= POLL_WAIT;
            waitCount <= PollInterval;
          end
        end
        COMMIT_END: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gpu_bus_arbiter.sv
// tb_gpu_bus_arbiter: scoreboard bench; a monitor logs bus/ack/commit events, each test pushes expected events and compares
module tb_gpu_bus_arbiter;
  logic        clock = 1'b0, reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0, commit = 1'b0;
  logic [63:0] addr0 = 64'd0, addr1 = 64'd0, wdata0 = 64'd0, wdata1 = 64'd0, controlBase = 64'd0;
  logic        ack0, ack1, commitDone, commitError, busRead, busWrite, busDataOutEnable, busy;
  logic [63:0] rdata, busAddress, busDataOut, busDataIn;
  typedef struct {byte k; logic [63:0] a; logic [63:0] d; int c;} evT;
  localparam logic [63:0] Ctrl = 64'h0200_0000_0000_0000;
  evT          obs[$];
  evT          exp[$];
  int          cyc = 0, readsSeen = 0, readBase = 0, busyPolls = 0;
  int          compared = 0, mismatched = 0, obsIdx = 0;
  logic        pollMode = 1'b0;
  logic [63:0] tbData = 64'd0;
  always #5 clock = ~clock;
  assign busDataIn = pollMode ? {63'b0, (readsSeen - readBase) < busyPolls} : tbData;
  gpu_bus_arbiter #(.PollLimit(16'd4)) dut (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .commit(commit), .controlBase(controlBase), .commitDone(commitDone),
    .commitError(commitError), .busAddress(busAddress), .busDataOut(busDataOut), .busRead(busRead),
    .busWrite(busWrite), .busDataOutEnable(busDataOutEnable), .busDataIn(busDataIn), .busy(busy)
  );
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (busRead) readsSeen <= readsSeen + 1;
  end
  always @(negedge clock) begin
    if (busRead && busWrite) obs.push_back('{k: "X", a: busAddress, d: busDataOut, c: cyc});
    else if (busWrite) obs.push_back('{k: busDataOutEnable ? "W" : "w", a: busAddress, d: busDataOut, c: cyc});
    else if (busRead) obs.push_back('{k: busDataOutEnable ? "r" : "R", a: busAddress, d: 64'd0, c: cyc});
    if (ack0) obs.push_back('{k: "A", a: 64'd0, d: rdata, c: cyc});
    if (ack1) obs.push_back('{k: "B", a: 64'd0, d: rdata, c: cyc});
    if (commitDone) obs.push_back('{k: "D", a: 64'd0, d: 64'd0, c: cyc});
    if (commitError) obs.push_back('{k: "E", a: 64'd0, d: 64'd0, c: cyc});
  end
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic drain(input int n, input int budget);
    int b = 0;
    while (obs.size() - obsIdx < n && b < budget) begin
      tick();
      b++;
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %0b want 0", busy); end
    compared++; if (busWrite !== 1'b0 || busRead !== 1'b0) begin mismatched++; $display("FAIL reset_rw got %0b%0b want 00", busWrite, busRead); end
    compared++; if (busAddress !== 64'd0 || busDataOut !== 64'd0 || busDataOutEnable !== 1'b0) begin mismatched++; $display("FAIL reset_bus got a=%h d=%h oe=%0b want 0", busAddress, busDataOut, busDataOutEnable); end
    compared++; if (rdata !== 64'd0) begin mismatched++; $display("FAIL reset_rdata got %h want 0", rdata); end
    compared++; if ({ack0, ack1, commitDone, commitError} !== 4'b0) begin mismatched++; $display("FAIL reset_pulses got %b want 0000", {ack0, ack1, commitDone, commitError}); end
    reset = 1'b0;
    tick();
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_idle_busy got %0b want 0", busy); end
    obsIdx = obs.size();
  endtask
  task automatic test_contention();
    evT got[$];
    reset = 1'b1;
    tick();
    tick();
    tbData = 64'h5555; wr0 = 1'b0; wr1 = 1'b1;
    addr0 = 64'h0200_0000_0000_0010; addr1 = 64'h0200_0000_0000_0020; wdata1 = 64'hAB;
    obsIdx = obs.size();
    reset = 1'b0; req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp.push_back('{k: "R", a: addr0, d: 64'd0, c: 0});
      exp.push_back('{k: "A", a: 64'd0, d: 64'h5555, c: 0});
      exp.push_back('{k: "W", a: addr1, d: 64'hAB, c: 0});
      exp.push_back('{k: "B", a: 64'd0, d: 64'h5555, c: 0});
    end
    drain(8, 60);
    req0 = 1'b0; req1 = 1'b0;
    repeat (6) tick();
    compared++; if (obs.size() - obsIdx !== exp.size()) begin mismatched++; $display("FAIL contention_count got %0d want %0d", obs.size() - obsIdx, exp.size()); end
    while (exp.size() > 0) begin
      evT e;
      evT o;
      e = exp.pop_front();
      o = '{k: "-", a: 64'd0, d: 64'd0, c: -100};
      if (obsIdx < obs.size()) o = obs[obsIdx];
      obsIdx++;
      got.push_back(o);
      compared++; if (o.k !== e.k || o.a !== e.a || o.d !== e.d) begin mismatched++; $display("FAIL contention_ev got %c a=%h d=%h want %c a=%h d=%h", o.k, o.a, o.d, e.k, e.a, e.d); end
    end
    for (int i = 3; i < 8; i += 2) begin
      compared++; if (got[i].c - got[i - 2].c !== 3) begin mismatched++; $display("FAIL contention_gap got %0d want 3", got[i].c - got[i - 2].c); end
    end
    obsIdx = obs.size();
  endtask
  task automatic test_single_write();
    evT got[$];
    int d0;
    tbData = 64'h77; wr0 = 1'b1; addr0 = 64'h0200_0000_0000_0004; wdata0 = 64'h41;
    req0 = 1'b1;
    d0 = cyc;
    exp.push_back('{k: "W", a: 64'h0200_0000_0000_0004, d: 64'h41, c: 0});
    exp.push_back('{k: "A", a: 64'd0, d: 64'h77, c: 0});
    tick();
    addr0 = 64'hFFFF; wdata0 = 64'd0; wr0 = 1'b0;
    drain(2, 20);
    req0 = 1'b0;
    repeat (5) tick();
    compared++; if (obs.size() - obsIdx !== exp.size()) begin mismatched++; $display("FAIL write_count got %0d want %0d", obs.size() - obsIdx, exp.size()); end
    while (exp.size() > 0) begin
      evT e;
      evT o;
      e = exp.pop_front();
      o = '{k: "-", a: 64'd0, d: 64'd0, c: -100};
      if (obsIdx < obs.size()) o = obs[obsIdx];
      obsIdx++;
      got.push_back(o);
      compared++; if (o.k !== e.k || o.a !== e.a || o.d !== e.d) begin mismatched++; $display("FAIL write_ev got %c a=%h d=%h want %c a=%h d=%h", o.k, o.a, o.d, e.k, e.a, e.d); end
    end
    compared++; if (got[0].c !== d0 + 1) begin mismatched++; $display("FAIL write_bus_cycle got %0d want %0d", got[0].c, d0 + 1); end
    compared++; if (got[1].c !== d0 + 2) begin mismatched++; $display("FAIL write_ack_latency got %0d want %0d", got[1].c, d0 + 2); end
    obsIdx = obs.size();
  endtask
  task automatic test_commit();
    evT got[$];
    int d0;
    pollMode = 1'b1; readBase = readsSeen; busyPolls = 2; controlBase = 64'h1C;
    exp.push_back('{k: "W", a: Ctrl, d: 64'h1D, c: 0});
    repeat (3) exp.push_back('{k: "R", a: Ctrl, d: 64'd0, c: 0});
    exp.push_back('{k: "D", a: 64'd0, d: 64'd0, c: 0});
    d0 = cyc;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    compared++; if (busy !== 1'b1 || busWrite !== 1'b1) begin mismatched++; $display("FAIL commit_wr_state got busy=%0b wr=%0b want 1 1", busy, busWrite); end
    drain(5, 60);
    repeat (5) tick();
    compared++; if (obs.size() - obsIdx !== exp.size()) begin mismatched++; $display("FAIL commit_count got %0d want %0d", obs.size() - obsIdx, exp.size()); end
    while (exp.size() > 0) begin
      evT e;
      evT o;
      e = exp.pop_front();
      o = '{k: "-", a: 64'd0, d: 64'd0, c: -100};
      if (obsIdx < obs.size()) o = obs[obsIdx];
      obsIdx++;
      got.push_back(o);
      compared++; if (o.k !== e.k || o.a !== e.a || o.d !== e.d) begin mismatched++; $display("FAIL commit_ev got %c a=%h d=%h want %c a=%h d=%h", o.k, o.a, o.d, e.k, e.a, e.d); end
    end
    compared++; if (got[0].c !== d0 + 2) begin mismatched++; $display("FAIL commit_start got %0d want %0d", got[0].c, d0 + 2); end
    for (int i = 1; i < 4; i++) begin
      compared++; if (got[i].c - got[i - 1].c !== 9) begin mismatched++; $display("FAIL commit_poll_gap got %0d want 9", got[i].c - got[i - 1].c); end
    end
    compared++; if (got[4].c - got[3].c !== 1) begin mismatched++; $display("FAIL commit_done_cycle got %0d want 1", got[4].c - got[3].c); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL commit_idle_busy got %0b want 0", busy); end
    obsIdx = obs.size();
  endtask
  task automatic test_timeout();
    evT got[$];
    pollMode = 1'b1; readBase = readsSeen; busyPolls = 100; controlBase = 64'h1000;
    exp.push_back('{k: "W", a: Ctrl, d: 64'h1001, c: 0});
    repeat (4) exp.push_back('{k: "R", a: Ctrl, d: 64'd0, c: 0});
    exp.push_back('{k: "E", a: 64'd0, d: 64'd0, c: 0});
    commit = 1'b1;
    tick();
    commit = 1'b0;
    drain(6, 80);
    repeat (15) tick();
    compared++; if (obs.size() - obsIdx !== exp.size()) begin mismatched++; $display("FAIL timeout_count got %0d want %0d", obs.size() - obsIdx, exp.size()); end
    while (exp.size() > 0) begin
      evT e;
      evT o;
      e = exp.pop_front();
      o = '{k: "-", a: 64'd0, d: 64'd0, c: -100};
      if (obsIdx < obs.size()) o = obs[obsIdx];
      obsIdx++;
      got.push_back(o);
      compared++; if (o.k !== e.k || o.a !== e.a || o.d !== e.d) begin mismatched++; $display("FAIL timeout_ev got %c a=%h d=%h want %c a=%h d=%h", o.k, o.a, o.d, e.k, e.a, e.d); end
    end
    compared++; if (readsSeen - readBase !== 4) begin mismatched++; $display("FAIL timeout_polls got %0d want 4", readsSeen - readBase); end
    obsIdx = obs.size();
  endtask
  task automatic test_commit_traffic();
    evT got[$];
    pollMode = 1'b1; readBase = readsSeen; busyPolls = 0; controlBase = 64'h1C;
    wr1 = 1'b1; addr1 = 64'h0200_0000_0000_0100; wdata1 = 64'hBEEF;
    wr0 = 1'b1; addr0 = 64'h0200_0000_0000_0200; wdata0 = 64'hCAFE;
    exp.push_back('{k: "W", a: 64'h0200_0000_0000_0100, d: 64'hBEEF, c: 0});
    exp.push_back('{k: "B", a: 64'd0, d: 64'd0, c: 0});
    exp.push_back('{k: "W", a: Ctrl, d: 64'h1D, c: 0});
    exp.push_back('{k: "R", a: Ctrl, d: 64'd0, c: 0});
    exp.push_back('{k: "D", a: 64'd0, d: 64'd0, c: 0});
    exp.push_back('{k: "W", a: 64'h0200_0000_0000_0200, d: 64'hCAFE, c: 0});
    exp.push_back('{k: "A", a: 64'd0, d: 64'd0, c: 0});
    req1 = 1'b1;
    tick();
    commit = 1'b1; req0 = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    req1 = 1'b0;
    drain(7, 60);
    req0 = 1'b0;
    repeat (6) tick();
    compared++; if (obs.size() - obsIdx !== exp.size()) begin mismatched++; $display("FAIL traffic_count got %0d want %0d", obs.size() - obsIdx, exp.size()); end
    while (exp.size() > 0) begin
      evT e;
      evT o;
      e = exp.pop_front();
      o = '{k: "-", a: 64'd0, d: 64'd0, c: -100};
      if (obsIdx < obs.size()) o = obs[obsIdx];
      obsIdx++;
      got.push_back(o);
      compared++; if (o.k !== e.k || o.a !== e.a || o.d !== e.d) begin mismatched++; $display("FAIL traffic_ev got %c a=%h d=%h want %c a=%h d=%h", o.k, o.a, o.d, e.k, e.a, e.d); end
    end
    compared++; if (got[2].c - got[1].c !== 2) begin mismatched++; $display("FAIL traffic_commit_next got %0d want 2", got[2].c - got[1].c); end
    compared++; if (got[5].c - got[4].c !== 2) begin mismatched++; $display("FAIL traffic_req0_after got %0d want 2", got[5].c - got[4].c); end
    obsIdx = obs.size();
  endtask
  task automatic test_reset_mid_poll();
    evT got[$];
    int d0;
    pollMode = 1'b1; readBase = readsSeen; busyPolls = 100; controlBase = 64'h1C;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    repeat (4) tick();
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL midpoll_busy_before got %0b want 1", busy); end
    reset = 1'b1;
    tick();
    compared++; if (busy !== 1'b0 || busRead !== 1'b0 || busWrite !== 1'b0) begin mismatched++; $display("FAIL midpoll_after_reset got busy=%0b rd=%0b wr=%0b want 000", busy, busRead, busWrite); end
    reset = 1'b0;
    repeat (15) tick();
    compared++; if (obs.size() - obsIdx !== 1) begin mismatched++; $display("FAIL midpoll_abandon got %0d events want 1", obs.size() - obsIdx); end
    obsIdx = obs.size();
    readBase = readsSeen; busyPolls = 0;
    exp.push_back('{k: "W", a: Ctrl, d: 64'h1D, c: 0});
    exp.push_back('{k: "R", a: Ctrl, d: 64'd0, c: 0});
    exp.push_back('{k: "D", a: 64'd0, d: 64'd0, c: 0});
    d0 = cyc;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    drain(3, 40);
    repeat (5) tick();
    compared++; if (obs.size() - obsIdx !== exp.size()) begin mismatched++; $display("FAIL midpoll_restart_count got %0d want %0d", obs.size() - obsIdx, exp.size()); end
    while (exp.size() > 0) begin
      evT e;
      evT o;
      e = exp.pop_front();
      o = '{k: "-", a: 64'd0, d: 64'd0, c: -100};
      if (obsIdx < obs.size()) o = obs[obsIdx];
      obsIdx++;
      got.push_back(o);
      compared++; if (o.k !== e.k || o.a !== e.a || o.d !== e.d) begin mismatched++; $display("FAIL midpoll_restart_ev got %c a=%h d=%h want %c a=%h d=%h", o.k, o.a, o.d, e.k, e.a, e.d); end
    end
    compared++; if (got[0].c !== d0 + 2) begin mismatched++; $display("FAIL midpoll_restart_start got %0d want %0d", got[0].c, d0 + 2); end
    obsIdx = obs.size();
  endtask
  initial begin
    test_reset();
    test_contention();
    test_single_write();
    test_commit();
    test_timeout();
    test_commit_traffic();
    test_reset_mid_poll();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
